// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: moves one 256-bit cache line to/from memory as a fixed 4-beat 64-bit burst.
// Optional LINE_BURST_EARLY_RESP_EN: respond in the final beat cycle and skip the DONE state.
//
// state | meaning
// IDLE  | waiting for a cache read_i / write_i request
// RD    | line fill: capturing beats from burst_i on each resp_i
// WR    | writeback: presenting buffered beats on burst_o on each resp_i
// DONE  | one-cycle resp_o pulse to the cache, requests not sampled
module line_burst_adaptor #(
    parameter int s_offset  = 5,
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst,
    parameter int cnt_width = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

`ifdef LINE_BURST_EARLY_RESP_EN
    localparam state_t after_last = IDLE;
`else
    localparam state_t after_last = DONE;
`endif

    localparam logic [cnt_width-1:0] last_cnt  = cnt_width'(num_beats - 1);
    localparam logic [31:0]          line_mask = ~32'((1 << s_offset) - 1);

    state_t                state, state_next;
    logic [cnt_width-1:0]  cnt;
    logic [s_line-1:0]     line_buf;
    logic [31:0]           addr_q;
    logic                  last_beat;

    assign last_beat = resp_i && (cnt == last_cnt);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // write has priority when both requests are presented together
                if (write_i)     state_next = WR;
                else if (read_i) state_next = RD;
            end
            RD, WR: if (last_beat) state_next = after_last;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            line_buf <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        line_buf <= line_i;
                        addr_q   <= address_i & line_mask;
                        cnt      <= '0;
                    end else if (read_i) begin
                        addr_q   <= address_i & line_mask;
                        cnt      <= '0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_buf[cnt*s_burst +: s_burst] <= burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: if (resp_i) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign address_o = addr_q;

    always_comb begin
        read_o  = (state == RD);
        write_o = (state == WR);
        burst_o = '0;
        if (state == WR) burst_o = line_buf[cnt*s_burst +: s_burst];
        line_o  = line_buf;
`ifdef LINE_BURST_EARLY_RESP_EN
        resp_o  = ((state == RD) || (state == WR)) && last_beat;
        // final read beat bypasses the buffer so the cache sees the whole line now
        if ((state == RD) && last_beat) line_o[s_line-1 -: s_burst] = burst_i;
`else
        resp_o  = (state == DONE);
`endif
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: directed test-plan steps followed by random transfers.
// Expectations come from a line-level model (beats concatenated, address aligned to 32 bytes).
module tb_line_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int compared = 0;
    int mismatched = 0;

`ifdef LINE_BURST_EARLY_RESP_EN
    localparam bit early = 1'b1;
`else
    localparam bit early = 1'b0;
`endif

    line_burst_adaptor dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] junk();
        return {$urandom, $urandom};
    endfunction

    // Strobe pattern: cycle i of the burst uses pat[i] while i < plen, then 1.
    task automatic do_read(input logic [31:0] a, input logic [255:0] line,
                           input logic [15:0] pat, input int plen);
        int k = 0;
        int i = 0;
        logic r;
        read_i = 1'b1; address_i = a; resp_i = 1'b1; burst_i = junk();
        #1;
        chk("rd_idle_read_o", 256'(read_o), 256'(0));
        step();
        while (k < 4 && i < 40) begin
            r = (i < plen) ? pat[i] : 1'b1;
            resp_i = r;
            burst_i = r ? line[k*64 +: 64] : junk();
            #1;
            chk("rd_read_o", 256'(read_o), 256'(1));
            chk("rd_address_o", 256'(address_o), 256'(a & 32'hFFFF_FFE0));
            chk("rd_resp_o_in_burst", 256'(resp_o), 256'(early && r && k == 3));
            if (early && r && k == 3) chk("rd_line_o_early", line_o, line);
            step();
            i++;
            if (r) k++;
        end
        if (k < 4) chk("rd_beat_budget", 256'(k), 256'(4));
        resp_i = 1'b0; burst_i = junk();
        if (!early) begin
            #1;
            chk("rd_resp_o_done", 256'(resp_o), 256'(1));
            chk("rd_read_o_done", 256'(read_o), 256'(0));
            chk("rd_line_o_done", line_o, line);
            read_i = 1'b0;
            step();
        end
        read_i = 1'b0;
        #1;
        chk("rd_resp_o_after", 256'(resp_o), 256'(0));
        chk("rd_read_o_after", 256'(read_o), 256'(0));
        chk("rd_line_o_after", line_o, line);
        chk("rd_address_hold", 256'(address_o), 256'(a & 32'hFFFF_FFE0));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                            input logic [15:0] pat, input int plen, input bit both);
        int k = 0;
        int i = 0;
        logic r;
        write_i = 1'b1; read_i = both; line_i = line; address_i = a; resp_i = 1'b0;
        #1;
        step();
        line_i = {junk(), junk(), junk(), junk()};
        while (k < 4 && i < 40) begin
            r = (i < plen) ? pat[i] : 1'b1;
            resp_i = r;
            burst_i = junk();
            #1;
            chk("wr_write_o", 256'(write_o), 256'(1));
            chk("wr_read_o", 256'(read_o), 256'(0));
            chk("wr_burst_o", 256'(burst_o), 256'(line[k*64 +: 64]));
            chk("wr_address_o", 256'(address_o), 256'(a & 32'hFFFF_FFE0));
            chk("wr_resp_o_in_burst", 256'(resp_o), 256'(early && r && k == 3));
            step();
            i++;
            if (r) k++;
        end
        if (k < 4) chk("wr_beat_budget", 256'(k), 256'(4));
        resp_i = 1'b0;
        if (!early) begin
            #1;
            chk("wr_resp_o_done", 256'(resp_o), 256'(1));
            chk("wr_write_o_done", 256'(write_o), 256'(0));
            write_i = 1'b0; read_i = 1'b0;
            step();
        end
        write_i = 1'b0; read_i = 1'b0;
        #1;
        chk("wr_resp_o_after", 256'(resp_o), 256'(0));
        chk("wr_write_o_after", 256'(write_o), 256'(0));
        chk("wr_burst_o_after", 256'(burst_o), 256'(0));
        chk("wr_line_buffer", line_o, line);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_line_o"}, line_o, 256'(0));
        chk({tag, "_address_o"}, 256'(address_o), 256'(0));
        chk({tag, "_burst_o"}, 256'(burst_o), 256'(0));
        chk({tag, "_read_o"}, 256'(read_o), 256'(0));
        chk({tag, "_write_o"}, 256'(write_o), 256'(0));
        chk({tag, "_resp_o"}, 256'(resp_o), 256'(0));
    endtask

    initial begin
        logic [255:0] fill_line;
        logic [255:0] wb_line;
        logic [255:0] rline;
        logic [15:0]  rpat;

        // reset state
        @(negedge clk);
        step();
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // fill, no stalls
        fill_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_read(32'h0000_1234, fill_line, 16'hFFFF, 0);

        // writeback, k = 3..0 top to bottom
        wb_line = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                   64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        do_write(32'h8000_0047, wb_line, 16'hFFFF, 0, 1'b0);

        // stalled read: strobes 1,0,0,1,1,0,1
        fill_line = {junk(), junk(), junk(), junk()};
        do_read(32'h0000_ABCD, fill_line, 16'b1011001, 7);

        // simultaneous read and write requests: write wins
        wb_line = {junk(), junk(), junk(), junk()};
        do_write(32'h1234_5678, wb_line, 16'hFFFF, 0, 1'b1);
        #1;
        chk("both_read_not_taken", 256'(read_o), 256'(0));
        step();
        #1;
        chk("both_still_idle", 256'(read_o | write_o), 256'(0));

        // reset during third writeback beat
        step();
        write_i = 1'b1; line_i = wb_line; address_i = 32'h0000_0F00;
        step();
        write_i = 1'b0;
        resp_i = 1'b1;
        step();
        step();
        #1;
        chk("rst_mid_write_o", 256'(write_o), 256'(1));
        rst = 1'b1;
        step();
        rst = 1'b0; resp_i = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        step();
        #1;
        chk("rst_mid_no_resp", 256'(resp_o), 256'(0));
        fill_line = {junk(), junk(), junk(), junk()};
        do_read(32'h0000_2040, fill_line, 16'b0110, 4);

        // random transfers
        for (int n = 0; n < 24; n++) begin
            rline = {junk(), junk(), junk(), junk()};
            rpat = 16'($urandom);
            if ($urandom_range(1, 0) == 1)
                do_write($urandom, rline, rpat, int'($urandom_range(12, 0)), 1'($urandom));
            else
                do_read($urandom, rline, rpat, int'($urandom_range(12, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
